// File: rtl/txnum_frame.sv
// txnum_frame: streams CH signed samples as one ASCII line ("v0,v1,...\n") through uarttx; macro TXNUM_FRAME_PREFIX_EN adds 0x/0b prefixes.

// uarttx: 8-bit UART serialiser, LSB first, optional even parity, STOP stop bits.
module uarttx #(
    parameter int I_CLK_FRQ = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int PARITY    = 0,
    parameter int STOP      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int DIV = I_CLK_FRQ / BAUD;
    localparam int NB  = 9 + (PARITY != 0 ? 1 : 0) + STOP;
    localparam int BW  = $clog2(NB + 1);
    localparam int KW  = DIV > 1 ? $clog2(DIV) : 1;
    logic [NB-1:0] sh_q, frame;
    logic [BW-1:0] bits_q;
    logic [KW-1:0] cnt_q;
    assign frame  = PARITY != 0 ? NB'({{STOP{1'b1}}, ^i_data, i_data, 1'b0}) : NB'({{STOP{1'b1}}, i_data, 1'b0});
    assign o_busy = bits_q != '0;
    assign o_tx   = o_busy ? sh_q[0] : 1'b1;
    // Shift the frame out one bit per DIV clocks; reset only takes hold between frames.
    always_ff @(posedge i_clk)
        if (i_rst && !o_busy) begin
            sh_q   <= '1;
            bits_q <= '0;
            cnt_q  <= '0;
        end else if (!o_busy) begin
            if (i_en) begin
                sh_q   <= frame;
                bits_q <= BW'(NB);
                cnt_q  <= KW'(DIV - 1);
            end
        end else if (cnt_q == '0) begin
            sh_q   <= {1'b1, sh_q[NB-1:1]};
            bits_q <= bits_q - 1'b1;
            cnt_q  <= KW'(DIV - 1);
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
endmodule

module txnum_frame #(
    parameter int         I_CLK_FRQ = 100_000_000,
    parameter int         BAUD      = 9600,
    parameter int         PARITY    = 0,
    parameter int         STOP      = 1,
    parameter int         SIZE      = 8,
    parameter int         CH        = 4,
    parameter int         DIGITS    = 0,
    parameter logic [7:0] SEP       = ","
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [CH*SIZE-1:0] i_data,
    input  logic [1:0]         i_radix,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);
    localparam int MW  = SIZE + 1;
    localparam int DW  = $clog2(SIZE + 1);
    localparam int CW  = CH > 1 ? $clog2(CH) : 1;
    localparam int AW  = CH * SIZE > 1 ? $clog2(CH * SIZE) : 1;
    localparam int BW  = $clog2(8 * SIZE);
    localparam int CIW = 16;
    typedef enum logic [2:0] {IDLE, CONV, SEND, WHI, WLO} state_t;
    state_t             state_q, state_d;
    logic [CH*SIZE-1:0] data_q, data_d;
    logic [1:0]         rad_q, rad_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [MW-1:0]      mag_q, mag_d, cur, nxt, ext;
    logic [DW-1:0]      ndig_q, ndig_d;
    logic [8*SIZE-1:0]  dbuf_q, dbuf_d;
    logic [CIW-1:0]     ci_q, ci_d, pre, pad, nd, e1, e2, e3, e4;
    logic               first_q, first_d, neg_q, neg_d, uen_q, uen_d, uart_busy, last;
    logic [7:0]         chr_q, chr_d, chr, asc, term;
    logic [3:0]         dv;
    logic [SIZE-1:0]    smp;
    logic [BW-1:0]      wr_idx, rd_idx;
    assign smp    = data_q[AW'(ch_q * SIZE) +: SIZE];
    assign ext    = {smp[SIZE-1], smp};
    assign cur    = first_q ? (ext[SIZE] ? -ext : ext) : mag_q;
    assign dv     = rad_q == 2'd1 ? 4'(cur) : rad_q == 2'd2 ? {3'b0, cur[0]} : 4'(64'(cur) % 64'd10);
    assign nxt    = rad_q == 2'd1 ? cur >> 4 : rad_q == 2'd2 ? cur >> 1 : MW'(64'(cur) / 64'd10);
    assign asc    = dv < 4'd10 ? 8'd48 + {4'b0, dv} : 8'd55 + {4'b0, dv};
`ifdef TXNUM_FRAME_PREFIX_EN
    assign pre    = (rad_q == 2'd1 || rad_q == 2'd2) ? CIW'(2) : '0;
`else
    assign pre    = '0;
`endif
    assign nd     = CIW'(ndig_q);
    assign pad    = (rad_q != 2'd3 && CIW'(DIGITS) > nd) ? CIW'(DIGITS) - nd : '0;
    assign e1     = {{(CIW-1){1'b0}}, neg_q};
    assign e2     = e1 + pre;
    assign e3     = e2 + pad;
    assign e4     = e3 + nd;
    assign last   = ci_q == e4;
    assign term   = ch_q == CW'(CH - 1) ? 8'h0A : SEP;
    assign wr_idx = BW'({ndig_q, 3'b000});
    assign rd_idx = BW'({e4 - ci_q - 1'b1, 3'b000});
    assign chr    = ci_q < e1 ? "-" : ci_q < e2 ? (ci_q == e1 ? "0" : rad_q == 2'd1 ? "x" : "b") :
                    ci_q < e3 ? "0" : ci_q < e4 ? dbuf_q[rd_idx +: 8] : term;
    assign o_busy = state_q != IDLE || uart_busy;
    // Next state: capture, one digit per CONV cycle, then a one-cycle uart_en per character with a busy high/low handshake.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rad_d   = rad_q;
        ch_d    = ch_q;
        mag_d   = mag_q;
        ndig_d  = ndig_q;
        dbuf_d  = dbuf_q;
        ci_d    = ci_q;
        first_d = first_q;
        neg_d   = neg_q;
        uen_d   = 1'b0;
        chr_d   = chr_q;
        o_done  = 1'b0;
        case (state_q)
            IDLE: if (i_en && !o_busy) begin
                data_d  = i_data;
                rad_d   = i_radix;
                ch_d    = '0;
                ndig_d  = '0;
                first_d = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                dbuf_d[wr_idx +: 8] = rad_q == 2'd3 ? "?" : asc;
                ndig_d  = ndig_q + 1'b1;
                mag_d   = nxt;
                first_d = 1'b0;
                neg_d   = first_q ? ext[SIZE] && rad_q != 2'd3 : neg_q;
                if (rad_q == 2'd3 || nxt == '0) begin
                    ci_d    = '0;
                    state_d = SEND;
                end
            end
            SEND: if (!uart_busy && !uen_q) begin
                uen_d   = 1'b1;
                chr_d   = chr;
                state_d = WHI;
            end
            WHI: if (uart_busy) state_d = WLO;
            WLO: if (!uart_busy) begin
                if (!last) begin
                    ci_d    = ci_q + 1'b1;
                    state_d = SEND;
                end else if (ch_q == CW'(CH - 1)) begin
                    o_done  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    ndig_d  = '0;
                    first_d = 1'b1;
                    state_d = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Control registers; reset abandons the line immediately.
    always_ff @(posedge i_clk)
        if (i_rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ndig_q  <= '0;
            ci_q    <= '0;
            first_q <= 1'b0;
            neg_q   <= 1'b0;
            uen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ndig_q  <= ndig_d;
            ci_q    <= ci_d;
            first_q <= first_d;
            neg_q   <= neg_d;
            uen_q   <= uen_d;
        end
    // Datapath registers need no reset: they are always written before use.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
        rad_q  <= rad_d;
        mag_q  <= mag_d;
        dbuf_q <= dbuf_d;
        chr_q  <= chr_d;
    end
    uarttx #(.I_CLK_FRQ(I_CLK_FRQ), .BAUD(BAUD), .PARITY(PARITY), .STOP(STOP)) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (uen_q),
        .i_data (chr_q),
        .o_tx   (o_tx),
        .o_busy (uart_busy)
    );
endmodule

// File: tb/tb_txnum_frame.sv
// tb_txnum_frame: directed checks of txnum_frame lines decoded from o_tx at 4 clocks per bit.
module tb_txnum_frame;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en = '0;
    logic [1:0]  rad = '0;
    logic [15:0] d0 = '0;
    logic [23:0] d1 = '0;
    logic [23:0] d2 = '0;
    logic [26:0] d3 = '0;
    logic [3:0]  tx, busy, done;
    int          n_assert = 0, n_fail = 0, cyc = 0, dcnt = 0, done_at = 0, sel = 0;
    int          t0, s3;
    string       rx_s = "";

    always #5 clk = ~clk;

    txnum_frame #(.I_CLK_FRQ(1_000_000), .BAUD(250_000), .SIZE(8), .CH(2), .DIGITS(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_data(d0), .i_radix(rad),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
    txnum_frame #(.I_CLK_FRQ(1_000_000), .BAUD(250_000), .SIZE(8), .CH(3), .DIGITS(3)) u1 (
        .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_data(d1), .i_radix(rad),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
    txnum_frame #(.I_CLK_FRQ(1_000_000), .BAUD(250_000), .SIZE(8), .CH(3), .DIGITS(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_en(en[2]), .i_data(d2), .i_radix(rad),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
    txnum_frame #(.I_CLK_FRQ(1_000_000), .BAUD(250_000), .SIZE(9), .CH(3), .DIGITS(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_en(en[3]), .i_data(d3), .i_radix(rad),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

    // UART receiver on the selected line: sample mid-bit, append each byte (newline shown as \n).
    initial begin
        forever begin
            @(negedge clk);
            if (tx[sel] === 1'b0) begin
                logic [7:0] b;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx[sel];
                end
                repeat (4) @(negedge clk);
                rx_s = (b == 8'h0A) ? $sformatf("%s\\n", rx_s) : $sformatf("%s%c", rx_s, b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_s(input string tag, input string got, input string exp);
        n_assert++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (done[sel]) begin
            dcnt++;
            done_at = cyc;
        end
    endtask

    task automatic run(input int idx, input string exp, input string tag, input bit extra, input int lim);
        int first_tx;
        int t;
        rx_s = "";
        sel = idx;
        dcnt = 0;
        done_at = -1;
        first_tx = 0;
        en[idx] = 1'b1;
        step();
        en[idx] = 1'b0;
        t = cyc;
        while (busy[idx] && cyc - t < 5000) begin
            if (first_tx == 0 && !tx[idx]) first_tx = cyc - t;
            if (extra) begin
                en[idx] = (cyc - t == 60 || cyc - t == 130);
                if (en[idx]) begin
                    d2 = 24'h090909;
                    rad = 2'd0;
                end
            end
            step();
        end
        en[idx] = 1'b0;
        check({tag, "_busy_ends"}, int'(busy[idx]), 0);
        check_s({tag, "_line"}, rx_s, exp);
        check({tag, "_done_count"}, dcnt, 1);
        check({tag, "_busy_after_done"}, cyc - done_at, 1);
        check({tag, "_first_start"}, int'(first_tx != 0 && first_tx <= lim), 1);
    endtask

    initial begin
        repeat (4) step();
        check("reset_tx_idle", int'(tx), 15);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (3) step();
        d0 = {8'd5, 8'h80};
        rad = 2'd0;
        run(0, "-128,5\\n", "dec_minneg", 1'b0, 12);
        d1 = {8'hD6, 8'd0, 8'd7};
        run(1, "007,000,-042\\n", "dec_pad3", 1'b0, 12);
        d2 = {8'd10, 8'd127, 8'hFF};
        rad = 2'd1;
        run(2, "-1,7F,A\\n", "hex", 1'b0, 12);
        d2 = {8'hFE, 8'd0, 8'd5};
        rad = 2'd2;
        run(2, "101,0,-10\\n", "bin", 1'b0, 12);
        d2 = {8'd3, 8'd2, 8'd1};
        rad = 2'd3;
        run(2, "?,?,?\\n", "invalid_busy_en", 1'b1, 12);
        repeat (100) step();
        check("busy_en_not_queued", int'(busy[2]), 0);
        check_s("busy_en_no_extra_line", rx_s, "?,?,?\\n");
        d2 = {8'd5, 8'd34, 8'd12};
        rad = 2'd0;
        rx_s = "";
        sel = 2;
        dcnt = 0;
        en[2] = 1'b1;
        step();
        en[2] = 1'b0;
        t0 = cyc;
        while (rx_s.len() < 2 && cyc - t0 < 3000) step();
        while (tx[2] && cyc - t0 < 3000) step();
        s3 = cyc;
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        while (busy[2] && cyc - t0 < 3000) step();
        check("rst_busy_after_stop", cyc - s3, 40);
        repeat (80) step();
        check_s("rst_line_cut", rx_s, "12,");
        check("rst_no_done", dcnt, 0);
        check("rst_idle", int'(busy[2]), 0);
        d2 = {8'd0, 8'd100, 8'hF9};
        run(2, "-7,100,0\\n", "after_rst", 1'b0, 12);
        d3 = {9'd255, 9'd0, 9'h1E1};
        rad = 2'd1;
`ifdef TXNUM_FRAME_PREFIX_EN
        run(3, "-0x1F,0x0,0xFF\\n", "prefix_hex", 1'b0, 13);
`else
        run(3, "-1F,0,FF\\n", "size9_hex", 1'b0, 13);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/txnum_frame.md
Name: txnum_frame

Overview:
- Multi-channel signed-number UART transmitter.
- On a start pulse, captures CH signed samples and converts each to ASCII in a radix selected at run time.
- Streams them as one line, "v0<SEP>v1<SEP>...v(CH-1)\n", through the existing uarttx serialiser with an 8-bit frame.
- Sits between datapath/debug logic and the board UART pin for telemetry logging.

Parameters:
- I_CLK_FRQ, 100_000_000, input clock frequency in Hz; passed to uarttx.
- BAUD, 9600, baud rate; passed to uarttx.
- PARITY, 0, parity enable; passed to uarttx.
- STOP, 1, stop bits; passed to uarttx.
- SIZE, 8, width of each signed sample (2..32).
- CH, 4, channel count (1..16).
- DIGITS, 0, minimum digit count, zero-padded on the left; 0 means no padding. Values longer than DIGITS are never truncated.
- SEP, ",", 8-bit separator character between channels.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_en  in  1  start pulse; sampled only when o_busy=0.
- i_data  in  CH*SIZE  packed signed samples; channel k is i_data[k*SIZE +: SIZE]. Channel 0 is sent first.
- i_radix  in  2  0=decimal, 1=hex (uppercase A-F), 2=binary, 3=invalid.
- o_tx  out  1  serial line, driven by uarttx.
- o_busy  out  1  high whenever state!=IDLE or uarttx is busy.
- o_done  out  1  one-cycle pulse when transmission of the terminating "\n" finishes.

Behaviour:
- Reset values:
  - state=IDLE, o_done=0, uart_en=0, all counters 0.
  - o_tx idles high through uarttx.
  - i_rst mid-line aborts immediately; no further characters are launched.
  - A character already inside uarttx completes, and o_busy stays high until it does.
- Capture (IDLE with i_en=1 and o_busy=0):
  - Latch all of i_data and i_radix.
  - Channel index=0; go to CONV on the next cycle.
  - i_en while busy is ignored; it is neither queued nor allowed to corrupt the latched data.
- CONV:
  - Magnitude is computed in SIZE+1 bits, so the most-negative value prints correctly: SIZE=8, -128 -> "-128".
  - Set neg flag.
  - Produce one digit per cycle, least significant first, into a digit buffer of depth SIZE.
  - Hex and binary use shift/mask; decimal uses combinational /10 and %10.
  - Zero magnitude yields the single digit "0". Conversion takes max(ndig,1) cycles.
  - Invalid radix yields the single character "?" for the channel, in 1 cycle.
  - pad = DIGITS>ndig ? DIGITS-ndig : 0.
- SEND, per channel, in order: "-" if neg (no character for positive), pad x "0", digits most significant first. Then SEP if channel<CH-1, else "\n".
  - After SEP, increment channel and return to CONV.
  - After "\n", go to IDLE and pulse o_done when uarttx busy falls.
- uarttx handshake:
  - Issue a character only when uart_busy=0 and uart_en was 0 in the previous cycle.
  - uart_en is a one-cycle pulse with current_char stable.
  - Then wait for uart_busy to be seen high and then low before issuing the next character; no character is ever dropped or duplicated.
- Output timing:
  - First character launches within SIZE+3 cycles of the capture edge.
  - Line length in characters: sum(sign+pad+digits) + CH.

Optional Feature:
- Macro: TXNUM_FRAME_PREFIX_EN.
- Defined: hex values get "0x" and binary values get "0b" after the sign and before the padding, e.g. "-0x1F". Decimal and invalid radix are unchanged.
- Undefined: no prefix logic is synthesised, and output is exactly as described in Behaviour.

Test Plan:
1. CH=2, SIZE=8, radix 0, DIGITS=0, data {ch0=-128, ch1=5}, pulse i_en -> UART bytes "-128,5\n"; o_done pulses once; o_busy drops the cycle after.
2. CH=3, SIZE=8, DIGITS=3, radix 0, data {7, 0, -42} -> "007,000,-042\n".
3. SIZE=8, radix 1, data {-1, 127, 10}; then radix 2, data {5, 0, -2} -> "-1,7F,A\n" then "101,0,-10\n".
4. Radix 3, data {1, 2, 3} -> "?,?,?\n". Pulse i_en twice more during the line -> exactly one line emitted, and data latched at the first pulse is unaffected.
5. Assert i_rst during the 3rd character of a line -> that character completes on o_tx, nothing follows, o_busy falls after its stop bit, o_done stays 0. A new i_en then yields a full, correct line.
6. With TXNUM_FRAME_PREFIX_EN defined, radix 1, data {-31, 0, 255 (SIZE=9)} -> "-0x1F,0x0,0xFF\n".
